// File: rtl/store_retire_buffer_if.sv
// Bundle of the retire-store, memory-drain and load-probe signals of the
// committed-store buffer. The master side is the ROB/memory/LSU environment,
// the slave side is the buffer itself.
interface store_retire_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              store_valid;
  logic [ADDR_W-1:0] store_addr;
  logic [DATA_W-1:0] store_data;
  logic [1:0]        store_size;
  logic              store_accepted;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [1:0]        mem_size;
  logic              mem_ack;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [1:0]        ld_size;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_stall;

  logic              empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output store_valid, store_addr, store_data, store_size,
    output mem_ack,
    output ld_valid, ld_addr, ld_size,
    input  store_accepted,
    input  mem_req, mem_addr, mem_data, mem_size,
    input  fwd_hit, fwd_data, fwd_stall,
    input  empty, count
  );

  modport slave (
    input  store_valid, store_addr, store_data, store_size,
    input  mem_ack,
    input  ld_valid, ld_addr, ld_size,
    output store_accepted,
    output mem_req, mem_addr, mem_data, mem_size,
    output fwd_hit, fwd_data, fwd_stall,
    output empty, count
  );
endinterface

// File: rtl/store_retire_buffer.sv
// Committed-store buffer: accepts retiring stores from the ROB, drains them
// in order to data memory and forwards buffered data to younger loads.
// Entries are architecturally committed, so nothing here is ever flushed.
module store_retire_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                  clock,
  input logic                  reset,
  store_retire_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [1:0]        size_q [DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic accept;
  logic mem_req;
  logic drain;

  logic [1:0]        store_size_norm;
  logic [3:0]        ld_mask;
  logic [3:0]        st_mask;
  logic [PTR_W-1:0]  scan_idx;
  logic              fwd_hit;
  logic              fwd_stall;
  logic [DATA_W-1:0] fwd_data;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    byte_mask = 4'b0001 << off;
      2'd1:    byte_mask = 4'b0011 << off;
      default: byte_mask = 4'hF;
    endcase
  endfunction

  // Keeps only the bits a load of the given size actually returns.
  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = DATA_W'(8'hFF);
      2'd1:    size_mask = DATA_W'(16'hFFFF);
      default: size_mask = '1;
    endcase
  endfunction

  assign mem_req = (count_q != '0);
  assign drain   = mem_req && bus.mem_ack;
  assign accept  = bus.store_valid && (count_q < CNT_W'(DEPTH));

  assign store_size_norm = (bus.store_size == 2'd3) ? 2'd2 : bus.store_size;

  assign bus.store_accepted = accept;
  assign bus.mem_req        = mem_req;
  assign bus.mem_addr       = mem_req ? addr_q[head_q] : '0;
  assign bus.mem_data       = mem_req ? data_q[head_q] : '0;
  assign bus.mem_size       = mem_req ? size_q[head_q] : 2'd0;
  assign bus.empty          = !mem_req;
  assign bus.count          = count_q;
  assign bus.fwd_hit        = fwd_hit;
  assign bus.fwd_stall      = fwd_stall;
  assign bus.fwd_data       = fwd_data;

  // FIFO state: write at tail on accept, retire head on ack, track occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= 2'd0;
      end
    end else begin
      if (accept) begin
        addr_q[tail_q] <= bus.store_addr;
        data_q[tail_q] <= bus.store_data;
        size_q[tail_q] <= store_size_norm;
        tail_q         <= tail_q + 1'b1;
      end
      if (drain) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(accept) - CNT_W'(drain);
    end
  end

  // Load probe: walk oldest to youngest so the youngest overlapping entry
  // is the one left standing, which equals a youngest-first first-match scan.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    st_mask   = 4'h0;
    scan_idx  = '0;
    ld_mask   = byte_mask(bus.ld_size, bus.ld_addr[1:0]);
    if (bus.ld_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        scan_idx = head_q + PTR_W'(i);
        st_mask  = byte_mask(size_q[scan_idx], addr_q[scan_idx][1:0]);
        if ((CNT_W'(i) < count_q) &&
            (addr_q[scan_idx][ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2]) &&
            ((st_mask & ld_mask) != 4'h0)) begin
          if ((ld_mask & ~st_mask) == 4'h0) begin
            fwd_hit   = 1'b1;
            fwd_stall = 1'b0;
            fwd_data  = ((data_q[scan_idx] << (8 * addr_q[scan_idx][1:0]))
                         >> (8 * bus.ld_addr[1:0])) & size_mask(bus.ld_size);
          end else begin
            fwd_hit   = 1'b0;
            fwd_stall = 1'b1;
            fwd_data  = '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_store_retire_buffer.sv
// Directed, table-driven bench for the committed-store buffer plus a few
// hand-written multi-cycle sequences (accept latency, reset mid-drain).
module tb_store_retire_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic        sv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [1:0]  ss;
    logic        ack;
    logic        lv;
    logic [31:0] la;
    logic [1:0]  ls;
    logic        acc;
    logic        req;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic [1:0]  msz;
    logic [2:0]  cnt;
    logic        emp;
    logic        hit;
    logic        stl;
    logic [31:0] fd;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cycles;

  vec_t vecs [40];
  vec_t rst_vec;

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  store_retire_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  store_retire_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic vec_t mk(
    input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [1:0] ss,
    input logic ack, input logic lv, input logic [31:0] la, input logic [1:0] ls,
    input logic acc, input logic req, input logic [31:0] maddr, input logic [31:0] mdata,
    input logic [1:0] msz, input logic [2:0] cnt, input logic emp,
    input logic hit, input logic stl, input logic [31:0] fd);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.ss = ss; v.ack = ack;
    v.lv = lv; v.la = la; v.ls = ls;
    v.acc = acc; v.req = req; v.maddr = maddr; v.mdata = mdata; v.msz = msz;
    v.cnt = cnt; v.emp = emp; v.hit = hit; v.stl = stl; v.fd = fd;
    return v;
  endfunction

  task automatic checkValue(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.store_valid = v.sv;
    bus.store_addr  = v.sa;
    bus.store_data  = v.sd;
    bus.store_size  = v.ss;
    bus.mem_ack     = v.ack;
    bus.ld_valid    = v.lv;
    bus.ld_addr     = v.la;
    bus.ld_size     = v.ls;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkValue("store_accepted", idx, 32'(bus.store_accepted), 32'(v.acc));
    checkValue("mem_req",        idx, 32'(bus.mem_req),        32'(v.req));
    checkValue("mem_addr",       idx, bus.mem_addr,            v.maddr);
    checkValue("mem_data",       idx, bus.mem_data,            v.mdata);
    checkValue("mem_size",       idx, 32'(bus.mem_size),       32'(v.msz));
    checkValue("count",          idx, 32'(bus.count),          32'(v.cnt));
    checkValue("empty",          idx, 32'(bus.empty),          32'(v.emp));
    checkValue("fwd_hit",        idx, 32'(bus.fwd_hit),        32'(v.hit));
    checkValue("fwd_stall",      idx, 32'(bus.fwd_stall),      32'(v.stl));
    checkValue("fwd_data",       idx, bus.fwd_data,            v.fd);
  endtask

  // Hard stop in case anything above ever waits forever.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test: reset, vector table, then hand-written sequences.
  initial begin
    // Fields: sv, sa, sd, ss, ack, lv, la, ls | acc, req, maddr, mdata, msz, cnt, emp, hit, stl, fd
    rst_vec  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Single store and drain
    vecs[0]  = mk(1, 32'h100, 32'hDEADBEEF, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'h100, 32'hDEADBEEF, 2, 1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 32'h100, 32'hDEADBEEF, 2, 1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Fill, backpressure, no full bypass, wraparound drain order
    vecs[4]  = mk(1, 32'h10, 32'hA0, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(1, 32'h14, 32'hA1, 2, 0, 0, 0, 0,  1, 1, 32'h10, 32'hA0, 2, 1, 0, 0, 0, 0);
    vecs[6]  = mk(1, 32'h18, 32'hA2, 2, 0, 0, 0, 0,  1, 1, 32'h10, 32'hA0, 2, 2, 0, 0, 0, 0);
    vecs[7]  = mk(1, 32'h1C, 32'hA3, 2, 0, 0, 0, 0,  1, 1, 32'h10, 32'hA0, 2, 3, 0, 0, 0, 0);
    vecs[8]  = mk(1, 32'h20, 32'hA4, 2, 0, 0, 0, 0,  0, 1, 32'h10, 32'hA0, 2, 4, 0, 0, 0, 0);
    vecs[9]  = mk(1, 32'h20, 32'hA4, 2, 1, 0, 0, 0,  0, 1, 32'h10, 32'hA0, 2, 4, 0, 0, 0, 0);
    vecs[10] = mk(1, 32'h20, 32'hA4, 2, 0, 0, 0, 0,  1, 1, 32'h14, 32'hA1, 2, 3, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 32'h14, 32'hA1, 2, 4, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 32'h18, 32'hA2, 2, 3, 0, 0, 0, 0);
    // Simultaneous accept and ack at count 2
    vecs[13] = mk(1, 32'h24, 32'hA5, 2, 1, 0, 0, 0,  1, 1, 32'h1C, 32'hA3, 2, 2, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'h20, 32'hA4, 2, 2, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 32'h20, 32'hA4, 2, 2, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 32'h24, 32'hA5, 2, 1, 0, 0, 0, 0);
    // Ack while empty is ignored
    vecs[17] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Byte and half forwarding from a word store
    vecs[19] = mk(1, 32'h200, 32'h11223344, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 1, 32'h202, 0,  0, 1, 32'h200, 32'h11223344, 2, 1, 0, 1, 0, 32'h22);
    vecs[21] = mk(0, 0, 0, 0, 1, 1, 32'h200, 1,  0, 1, 32'h200, 32'h11223344, 2, 1, 0, 1, 0, 32'h3344);
    vecs[22] = mk(0, 0, 0, 0, 0, 1, 32'h202, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Same-cycle store invisible, then youngest-entry priority
    vecs[23] = mk(1, 32'h300, 32'hAAAAAAAA, 2, 0, 1, 32'h300, 2,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[24] = mk(1, 32'h300, 32'hBBBBBBBB, 2, 0, 1, 32'h300, 2,  1, 1, 32'h300, 32'hAAAAAAAA, 2, 1, 0, 1, 0, 32'hAAAAAAAA);
    vecs[25] = mk(0, 0, 0, 0, 0, 1, 32'h300, 2,  0, 1, 32'h300, 32'hAAAAAAAA, 2, 2, 0, 1, 0, 32'hBBBBBBBB);
    vecs[26] = mk(0, 0, 0, 0, 1, 0, 32'h300, 2,  0, 1, 32'h300, 32'hAAAAAAAA, 2, 2, 0, 0, 0, 0);
    vecs[27] = mk(0, 0, 0, 0, 1, 1, 32'h300, 2,  0, 1, 32'h300, 32'hBBBBBBBB, 2, 1, 0, 1, 0, 32'hBBBBBBBB);
    // Partial overlap stalls until drained
    vecs[28] = mk(1, 32'h400, 32'hCC, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[29] = mk(0, 0, 0, 0, 0, 1, 32'h400, 2,  0, 1, 32'h400, 32'hCC, 0, 1, 0, 0, 1, 0);
    vecs[30] = mk(0, 0, 0, 0, 1, 1, 32'h400, 2,  0, 1, 32'h400, 32'hCC, 0, 1, 0, 0, 1, 0);
    vecs[31] = mk(0, 0, 0, 0, 0, 1, 32'h400, 2,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Illegal size 3 behaves as a word
    vecs[32] = mk(1, 32'h500, 32'h55667788, 3, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[33] = mk(0, 0, 0, 0, 0, 1, 32'h502, 1,  0, 1, 32'h500, 32'h55667788, 2, 1, 0, 1, 0, 32'h5566);
    vecs[34] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 32'h500, 32'h55667788, 2, 1, 0, 0, 0, 0);
    vecs[35] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Same word, disjoint bytes: no overlap; then exact byte hit at offset 1
    vecs[36] = mk(1, 32'h401, 32'hDD, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[37] = mk(0, 0, 0, 0, 0, 1, 32'h400, 0,  0, 1, 32'h401, 32'hDD, 0, 1, 0, 0, 0, 0);
    vecs[38] = mk(0, 0, 0, 0, 1, 1, 32'h401, 0,  0, 1, 32'h401, 32'hDD, 0, 1, 0, 1, 0, 32'hDD);
    vecs[39] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    applyStimulus(rst_vec);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2;
    checkOutput(rst_vec, -1);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput(vecs[i], i);
      @(negedge clock);
    end

    // Accept-to-memory latency, with a bounded wait on mem_req
    applyStimulus(rst_vec);
    bus.store_valid = 1'b1;
    bus.store_addr  = 32'h600;
    bus.store_data  = 32'h12345678;
    bus.store_size  = 2'd2;
    #2;
    checkValue("latency_accept", 100, 32'(bus.store_accepted), 32'd1);
    @(negedge clock);
    bus.store_valid = 1'b0;
    cycles = 1;
    while (bus.mem_req !== 1'b1 && cycles < 8) begin
      @(negedge clock);
      cycles++;
    end
    #2;
    checkValue("latency_cycles", 101, 32'(cycles), 32'd1);
    checkValue("latency_addr",   102, bus.mem_addr, 32'h600);

    // Reset in the middle of a drain discards everything
    bus.store_valid = 1'b1;
    bus.store_addr  = 32'h604;
    bus.store_data  = 32'h9ABCDEF0;
    #2;
    checkValue("second_accept", 103, 32'(bus.store_accepted), 32'd1);
    @(negedge clock);
    bus.store_valid = 1'b0;
    #2;
    checkValue("pre_reset_count", 104, 32'(bus.count), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    #2;
    checkValue("mid_reset_count",   105, 32'(bus.count),   32'd0);
    checkValue("mid_reset_empty",   106, 32'(bus.empty),   32'd1);
    checkValue("mid_reset_req",     107, 32'(bus.mem_req), 32'd0);
    checkValue("mid_reset_addr",    108, bus.mem_addr,     32'h0);
    checkValue("mid_reset_data",    109, bus.mem_data,     32'h0);
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    @(negedge clock);
    #2;
    checkValue("post_reset_count",  110, 32'(bus.count),   32'd0);
    checkValue("post_reset_empty",  111, 32'(bus.empty),   32'd1);
    bus.mem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
